ndpqs_rr_sched: RTL

- Round-robin output scheduler for the per-port queue system.
- Tracks an occupancy counter per queue from enqueue events, and from dequeues that this block itself grants.
- Each grant selects one non-empty, unmasked queue and presents its index on a valid/ready handshake to the downstream dequeue/read logic.
- Sits between the queue storage (enqueue side) and the output datapath (dequeue side).

---
 rtl/ndpqs_rr_sched_if.sv | 12 +
 rtl/ndpqs_rr_sched.sv | 121 ++++++++++++
 2 files changed

// File: rtl/ndpqs_rr_sched_if.sv
// Grant handshake between the round-robin scheduler and the dequeue/read logic.
// master = scheduler (drives valid/qid), slave = downstream (drives ready).
interface ndpqs_rr_sched_if #(
    parameter int QID_WIDTH = 3
);
    logic                 out_valid;
    logic [QID_WIDTH-1:0] out_qid;
    logic                 out_ready;

    modport master (output out_valid, output out_qid, input out_ready);
    modport slave  (input out_valid, input out_qid, output out_ready);
endinterface

// File: rtl/ndpqs_rr_sched.sv
// Round-robin queue scheduler with per-queue occupancy counters; enqueue to grant >= 2 cycles, one grant per 2 cycles.
// Grant is held (valid/qid stable) until out_ready; enqueues to a full queue are dropped and flagged on enq_drop.
module ndpqs_rr_sched #(
    parameter int NUM_QUEUES  = 8,
    parameter int QID_WIDTH   = 3,
    parameter int DEPTH_WIDTH = 12
) (
    input  logic                              clk,
    input  logic                              rst,
    input  logic                              sched_en,
    input  logic [NUM_QUEUES-1:0]             q_mask,
    input  logic [NUM_QUEUES-1:0]             enq_valid,
    output logic [NUM_QUEUES-1:0]             enq_ready,
    output logic [NUM_QUEUES-1:0]             enq_drop,
    ndpqs_rr_sched_if.master                  gnt,
    output logic [NUM_QUEUES*DEPTH_WIDTH-1:0] depth_flat,
    output logic                              all_empty
);

    typedef enum logic {ARB, GRANT} state_t;

    state_t                 state_q, state_d;
    logic [DEPTH_WIDTH-1:0] depth_q [NUM_QUEUES];
    logic [DEPTH_WIDTH-1:0] depth_d [NUM_QUEUES];
    logic [QID_WIDTH-1:0]   ptr_q, ptr_d;
    logic [QID_WIDTH-1:0]   qid_q, qid_d;
    logic                   vld_q, vld_d;
    logic [NUM_QUEUES-1:0]  drop_q, drop_d;
    logic [NUM_QUEUES-1:0]  eligible, inc, dec;
    logic                   accept, found;
    logic [QID_WIDTH-1:0]   winner;

    assign gnt.out_valid = vld_q;
    assign gnt.out_qid   = qid_q;
    assign enq_drop      = drop_q;
    assign accept        = vld_q & gnt.out_ready;

    function automatic logic [QID_WIDTH-1:0] rot_idx(input logic [QID_WIDTH-1:0] base, input int ofs);
        int s;
        s = int'(base) + ofs;
        if (s >= NUM_QUEUES) s = s - NUM_QUEUES;
        return QID_WIDTH'(s);
    endfunction

    // enq_ready looks at the pre-update count, so a full queue drops even when dequeued this cycle
    always_comb begin
        enq_ready  = '0;
        eligible   = '0;
        inc        = '0;
        dec        = '0;
        drop_d     = '0;
        depth_flat = '0;
        all_empty  = 1'b1;
        for (int i = 0; i < NUM_QUEUES; i++) begin
            enq_ready[i] = (depth_q[i] != {DEPTH_WIDTH{1'b1}});
            eligible[i]  = q_mask[i] & (depth_q[i] != '0);
            inc[i]       = enq_valid[i] & enq_ready[i];
            dec[i]       = accept & (qid_q == QID_WIDTH'(i));
            drop_d[i]    = enq_valid[i] & ~enq_ready[i];
            depth_d[i]   = depth_q[i] + DEPTH_WIDTH'(inc[i]) - DEPTH_WIDTH'(dec[i]);
            depth_flat[i*DEPTH_WIDTH +: DEPTH_WIDTH] = depth_q[i];
            if (depth_q[i] != '0) all_empty = 1'b0;
        end
    end

    always_comb begin
        found  = 1'b0;
        winner = '0;
        for (int k = 0; k < NUM_QUEUES; k++) begin
            if (!found && eligible[rot_idx(ptr_q, k)]) begin
                found  = 1'b1;
                winner = rot_idx(ptr_q, k);
            end
        end
    end

    always_comb begin
        state_d = state_q;
        vld_d   = vld_q;
        qid_d   = qid_q;
        ptr_d   = ptr_q;
        case (state_q)
            ARB: begin
                vld_d = 1'b0;
                if (sched_en && found) begin
                    qid_d   = winner;
                    vld_d   = 1'b1;
                    state_d = GRANT;
                end
            end
            GRANT: begin
                // an issued grant is never withdrawn by sched_en or q_mask
                if (gnt.out_ready) begin
                    vld_d   = 1'b0;
                    state_d = ARB;
                    ptr_d   = (qid_q == QID_WIDTH'(NUM_QUEUES - 1)) ? '0 : qid_q + QID_WIDTH'(1);
                end
            end
            default: state_d = ARB;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= ARB;
            vld_q   <= 1'b0;
            qid_q   <= '0;
            ptr_q   <= '0;
            drop_q  <= '0;
            for (int i = 0; i < NUM_QUEUES; i++) depth_q[i] <= '0;
        end else begin
            state_q <= state_d;
            vld_q   <= vld_d;
            qid_q   <= qid_d;
            ptr_q   <= ptr_d;
            drop_q  <= drop_d;
            for (int i = 0; i < NUM_QUEUES; i++) depth_q[i] <= depth_d[i];
        end
    end

endmodule
